// File: rtl/hilo_div_commit_if.sv
// Bundle between the EX-stage divider/issue logic and the HI/LO commit block.
interface hilo_div_commit_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic              issue_signed;
  logic              dividend_neg;
  logic              divisor_neg;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;
  logic              wb_allin;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] mt_wdata;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;
  logic              busy;
  logic              commit;

  // Pipeline / divider side.
  modport master (
    output flush, issue_valid, issue_signed, dividend_neg, divisor_neg,
    output div_done, div_quotient, div_remainder, wb_allin, hi_we, lo_we, mt_wdata,
    input  issue_ready, hi_rdata, lo_rdata, busy, commit
  );

  // HI/LO commit block side.
  modport slave (
    input  flush, issue_valid, issue_signed, dividend_neg, divisor_neg,
    input  div_done, div_quotient, div_remainder, wb_allin, hi_we, lo_we, mt_wdata,
    output issue_ready, hi_rdata, lo_rdata, busy, commit
  );
endinterface

// File: rtl/hilo_div_commit.sv
// Sign-corrects the unsigned divider result for DIV/DIVU and commits it to HI/LO,
// holding it under write-back backpressure. Also services MTHI/MTLO.
module hilo_div_commit #(
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               reset,
  hilo_div_commit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] buf_quo_q, buf_quo_d;
  logic [DATA_W-1:0] buf_rem_q, buf_rem_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              commit_q, commit_d;

  logic              div_we;
  logic [DATA_W-1:0] div_lo;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] corr_quo;
  logic [DATA_W-1:0] corr_rem;

  // Two's-complement correction of the magnitude result (wraps for 0x80000000).
  always_comb begin
    corr_quo = neg_quo_q ? -bus.div_quotient  : bus.div_quotient;
    corr_rem = neg_rem_q ? -bus.div_remainder : bus.div_remainder;
  end

  // Next-state, buffer and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    buf_quo_d = buf_quo_q;
    buf_rem_d = buf_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    commit_d  = 1'b0;
    div_we    = 1'b0;
    div_lo    = buf_quo_q;
    div_hi    = buf_rem_q;

    unique case (state_q)
      StIdle: begin
        if (bus.issue_valid && !bus.flush) begin
          neg_quo_d = bus.issue_signed & (bus.dividend_neg ^ bus.divisor_neg);
          neg_rem_d = bus.issue_signed & bus.dividend_neg;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.div_done) begin
          if (bus.wb_allin) begin
            // Bypass: commit straight from the divider outputs.
            div_we   = 1'b1;
            div_lo   = corr_quo;
            div_hi   = corr_rem;
            commit_d = 1'b1;
            state_d  = StIdle;
          end else begin
            buf_quo_d = corr_quo;
            buf_rem_d = corr_rem;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (bus.flush) begin
          buf_quo_d = '0;
          buf_rem_d = '0;
          state_d   = StIdle;
        end else if (bus.wb_allin) begin
          div_we   = 1'b1;
          commit_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (div_we) begin
      lo_d = div_lo;
      hi_d = div_hi;
    end
    // MTHI/MTLO is the younger instruction, so it overrides a same-edge division commit.
    if (bus.lo_we) lo_d = bus.mt_wdata;
    if (bus.hi_we) hi_d = bus.mt_wdata;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      buf_quo_q <= '0;
      buf_rem_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      buf_quo_q <= buf_quo_d;
      buf_rem_q <= buf_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      commit_q  <= commit_d;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    bus.issue_ready = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.hi_rdata    = hi_q;
    bus.lo_rdata    = lo_q;
    bus.commit      = commit_q;
  end

endmodule

// File: tb/tb_hilo_div_commit.sv
// Self-checking bench for hilo_div_commit: vector table plus directed corner sequences,
// with a scoreboard of expected HI/LO values consumed on every commit pulse.
module tb_hilo_div_commit;

  logic clk = 1'b0;
  logic reset;

  hilo_div_commit_if #(.DATA_W(32)) bus ();

  hilo_div_commit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  typedef struct {
    string       name;
    logic        sgn;
    logic        dn;
    logic        vn;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_lo;
  logic [31:0] model_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; sample #1 after the edge and drain the scoreboard on commit.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.commit === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_commit: got commit=1 expected no commit");
      end else begin
        e = sb.pop_front();
        check("sb_lo", bus.lo_rdata, e.lo);
        check("sb_hi", bus.hi_rdata, e.hi);
      end
    end
  endtask

  task automatic issue(input logic sgn, input logic dn, input logic vn);
    bus.issue_valid  = 1'b1;
    bus.issue_signed = sgn;
    bus.dividend_neg = dn;
    bus.divisor_neg  = vn;
    tick();
    bus.issue_valid  = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] q, input logic [31:0] r);
    bus.div_done      = 1'b1;
    bus.div_quotient  = q;
    bus.div_remainder = r;
    tick();
    bus.div_done      = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    issue(v.sgn, v.dn, v.vn);
    check({v.name, "_busy"}, 32'(bus.busy), 32'd1);
    tick();
    tick();
    bus.wb_allin = 1'b1;
    e.lo = v.lo;
    e.hi = v.hi;
    sb.push_back(e);
    model_lo = v.lo;
    model_hi = v.hi;
    done_pulse(v.q, v.r);
    check({v.name, "_commit"}, 32'(bus.commit), 32'd1);
    check({v.name, "_idle"}, 32'(bus.issue_ready), 32'd1);
    check({v.name, "_lo"}, bus.lo_rdata, v.lo);
    check({v.name, "_hi"}, bus.hi_rdata, v.hi);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{"divu_3r0",   1'b0, 1'b0, 1'b0, 32'd3, 32'd0, 32'd3, 32'd0};
    vecs[1] = '{"div_m7_2",   1'b1, 1'b1, 1'b0, 32'd3, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2] = '{"div_7_m2",   1'b1, 1'b0, 1'b1, 32'd3, 32'd1, 32'hFFFF_FFFD, 32'd1};
    vecs[3] = '{"div_m7_m2",  1'b1, 1'b1, 1'b1, 32'd3, 32'd1, 32'd3, 32'hFFFF_FFFF};
    vecs[4] = '{"divu_signs", 1'b0, 1'b1, 1'b1, 32'd7, 32'd5, 32'd7, 32'd5};
    vecs[5] = '{"div_minint", 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0};
    vecs[6] = '{"divu_by0",   1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h55, 32'hFFFF_FFFF, 32'h55};
    vecs[7] = '{"div_by0_n",  1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'hFFFF_FFFB};

    reset             = 1'b1;
    bus.flush         = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_signed  = 1'b0;
    bus.dividend_neg  = 1'b0;
    bus.divisor_neg   = 1'b0;
    bus.div_done      = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    bus.wb_allin      = 1'b1;
    bus.hi_we         = 1'b0;
    bus.lo_we         = 1'b0;
    bus.mt_wdata      = '0;
    model_lo          = '0;
    model_hi          = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_hi", bus.hi_rdata, 32'd0);
    check("rst_lo", bus.lo_rdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.issue_ready), 32'd1);
    check("rst_commit", 32'(bus.commit), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      tick();
      check("commit_once", 32'(bus.commit), 32'd0);
    end

    // div_done in IDLE is ignored.
    done_pulse(32'hDEAD, 32'hBEEF);
    check("idle_done_commit", 32'(bus.commit), 32'd0);
    check("idle_done_lo", bus.lo_rdata, model_lo);

    // Backpressure: result held three cycles, then committed exactly once.
    issue(1'b0, 1'b0, 1'b0);
    tick();
    bus.wb_allin = 1'b0;
    done_pulse(32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_lo", bus.lo_rdata, model_lo);
      check("hold_hi", bus.hi_rdata, model_hi);
      tick();
    end
    bus.wb_allin = 1'b1;
    e.lo = 32'd9;
    e.hi = 32'd4;
    sb.push_back(e);
    model_lo = 32'd9;
    model_hi = 32'd4;
    tick();
    check("hold_commit", 32'(bus.commit), 32'd1);
    check("hold_lo_upd", bus.lo_rdata, 32'd9);
    check("hold_hi_upd", bus.hi_rdata, 32'd4);
    check("hold_idle", 32'(bus.busy), 32'd0);
    tick();
    check("hold_commit_once", 32'(bus.commit), 32'd0);

    // Flush in WAIT, then a late div_done must not write.
    issue(1'b1, 1'b1, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_wait_busy", 32'(bus.busy), 32'd0);
    done_pulse(32'h77, 32'h11);
    check("flush_wait_lo", bus.lo_rdata, model_lo);
    check("flush_wait_commit", 32'(bus.commit), 32'd0);

    // Flush coincident with wb_allin in HOLD.
    issue(1'b0, 1'b0, 1'b0);
    bus.wb_allin = 1'b0;
    done_pulse(32'h66, 32'h22);
    check("flush_hold_busy", 32'(bus.busy), 32'd1);
    bus.flush    = 1'b1;
    bus.wb_allin = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_hold_idle", 32'(bus.busy), 32'd0);
    check("flush_hold_lo", bus.lo_rdata, model_lo);
    check("flush_hold_hi", bus.hi_rdata, model_hi);
    check("flush_hold_commit", 32'(bus.commit), 32'd0);

    // Issue under flush in IDLE is dropped.
    bus.flush = 1'b1;
    issue(1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    check("flush_issue_busy", 32'(bus.busy), 32'd0);

    // MTLO on the same edge as a division commit.
    issue(1'b0, 1'b0, 1'b0);
    bus.lo_we    = 1'b1;
    bus.mt_wdata = 32'h1234;
    e.lo = 32'h1234;
    e.hi = 32'd2;
    sb.push_back(e);
    model_lo = 32'h1234;
    model_hi = 32'd2;
    done_pulse(32'd5, 32'd2);
    bus.lo_we = 1'b0;
    check("mt_coll_lo", bus.lo_rdata, 32'h1234);
    check("mt_coll_hi", bus.hi_rdata, 32'd2);

    // Plain MTHI in IDLE.
    bus.hi_we    = 1'b1;
    bus.mt_wdata = 32'hABCD;
    tick();
    bus.hi_we = 1'b0;
    model_hi  = 32'hABCD;
    check("mthi_hi", bus.hi_rdata, 32'hABCD);
    check("mthi_lo", bus.lo_rdata, model_lo);
    check("mthi_commit", 32'(bus.commit), 32'd0);

    // Reset mid-HOLD.
    issue(1'b0, 1'b0, 1'b0);
    bus.wb_allin = 1'b0;
    done_pulse(32'd8, 32'd1);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.wb_allin = 1'b1;
    model_lo     = '0;
    model_hi     = '0;
    check("rst_hold_hi", bus.hi_rdata, 32'd0);
    check("rst_hold_lo", bus.lo_rdata, 32'd0);
    check("rst_hold_busy", 32'(bus.busy), 32'd0);
    check("rst_hold_commit", 32'(bus.commit), 32'd0);
    tick();
    check("rst_hold_nocommit", 32'(bus.commit), 32'd0);
    run_vec(vecs[1]);
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_div_commit.md
# hilo_div_commit

Downstream companion of the iterative unsigned divider in the EX stage. Captures each division's operand signs at issue and waits for the divider's completion strobe. It then applies MIPS DIV/DIVU sign correction to the unsigned quotient/remainder and commits them to the architectural HI/LO registers under write-back backpressure. It also services MTHI/MTLO writes and exposes HI/LO and a busy flag used to stall MFHI/MFLO.

## Interface
- DATA_W, 32, width of operands, quotient, remainder, HI, LO
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  kill in-flight/held division; no HI/LO write
- issue_valid  in  1  division launched to divider this cycle (same cycle as divider CE_in)
- issue_ready  out  1  block can accept an issue (state IDLE)
- issue_signed  in  1  1 = DIV, 0 = DIVU
- dividend_neg  in  1  sign bit of original dividend (ignored if !issue_signed)
- divisor_neg  in  1  sign bit of original divisor (ignored if !issue_signed)
- div_done  in  1  divider result valid (divider CE_out), single-cycle pulse
- div_quotient  in  DATA_W  unsigned quotient of magnitudes
- div_remainder  in  DATA_W  unsigned remainder of magnitudes
- wb_allin  in  1  write-back stage can accept; commit permitted
- hi_we, lo_we  in  1 each  MTHI/MTLO write enables
- mt_wdata  in  DATA_W  MTHI/MTLO data
- hi_rdata, lo_rdata  out  DATA_W  committed HI/LO
- busy  out  1  state != IDLE
- commit  out  1  registered pulse, high the cycle after HI/LO updated by a division

## Operation
- States: IDLE, WAIT (divider running), HOLD (corrected result buffered, waiting wb_allin).
- IDLE: issue_valid && !flush -> capture neg_q = issue_signed & (dividend_neg ^ divisor_neg), neg_r = issue_signed & dividend_neg -> WAIT.
- WAIT: div_done -> corrected q = neg_q ? -div_quotient : div_quotient, r = neg_r ? -div_remainder : div_remainder (two's complement, DATA_W bits, wrap).
  - if wb_allin: write LO<=q, HI<=r at this edge -> IDLE (bypass, no HOLD).
  - else: store q/r in buffer -> HOLD.
- HOLD: wb_allin -> LO<=buffered q, HI<=buffered r -> IDLE.
- flush in WAIT or HOLD -> IDLE, no HI/LO write, buffer discarded; flush beats div_done and wb_allin in the same cycle. flush in IDLE with issue_valid: issue ignored.
- issue_valid while not IDLE: ignored (issue_ready=0; upstream must not assert).
- div_done outside WAIT: ignored.
- MTHI/MTLO: applied in any state. Same edge as a division commit: mt_wdata wins for the written register (younger instruction); the other register takes the division result.
- Divide by zero: no special case; core's unsigned outputs are corrected and committed as-is.
- Special value: DIV 0x80000000 / 0xFFFFFFFF -> core gives 0x80000000 r 0; negation wraps -> LO=0x80000000, HI=0.
- reset: state IDLE, HI=0, LO=0, buffer=0, commit=0, busy=0; overrides every other input including mid-division.

## Timing
- issue_ready = (state==IDLE), busy = (state!=IDLE): combinational from state.
- Issue at edge T -> WAIT from T+1. div_done sampled in WAIT at edge D.
- Bypass: wb_allin at D -> HI/LO visible on hi_rdata/lo_rdata from D+1, commit high during D+1, IDLE at D+1 (new issue accepted in cycle D+1).
- Held: earliest commit edge D+1; commit pulse and new HI/LO the cycle after the commit edge.
- MT write at edge M -> visible from M+1. No internal forwarding of pending division results; consumers stall on busy.
- Reset outputs: hi_rdata=0, lo_rdata=0, busy=0, issue_ready=1, commit=0.

## Test plan
- Unsigned: DIVU issue, div_done with q=3, r=0, wb_allin=1 -> next cycle LO=3, HI=0, commit=1, busy=0.
- Signed: DIV -7/2 (dividend_neg=1, divisor_neg=0), core q=3 r=1 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; 7/-2 -> LO=0xFFFFFFFD, HI=1.
- Backpressure: div_done with wb_allin=0 for 3 cycles -> state HOLD, HI/LO unchanged, busy=1; wb_allin=1 -> HI/LO updated next cycle, commit pulses once.
- Flush: flush in WAIT, later div_done -> no write; flush coincident with wb_allin in HOLD -> no write, IDLE next cycle.
- MT collision: MTLO 0x1234 on the same edge as a division commit (q=5, r=2) -> LO=0x1234, HI=2.
- Reset mid-HOLD -> HI=LO=0, busy=0, commit=0 next cycle; subsequent issue works normally.
